// File: rtl/npu_spi_pkg.sv
// Shared types and frame layout for the NPU SPI command/response master.
package npu_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_CMD,
        ST_WAIT_DONE,
        ST_GAP,
        ST_SHIFT_RESP,
        ST_HOLD
    } state_t;

    localparam int FRAME_BITS = 24;
    localparam int RESP_BITS  = 8;

    localparam int CMD_MSB    = 23;
    localparam int CMD_LSB    = 16;
    localparam int TILE_I_MSB = 15;
    localparam int TILE_I_LSB = 13;
    localparam int TILE_J_MSB = 12;
    localparam int TILE_J_LSB = 10;
    localparam int OP_MSB     = 9;
    localparam int OP_LSB     = 7;
    localparam int ARG_MSB    = 6;
    localparam int ARG_LSB    = 0;

endpackage

// File: rtl/npu_spi_sclk_gen.sv
// Half-period tick and mode-0 sclk level; counter and sclk sit at 0 whenever cleared.
module npu_spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic sclk
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = en && !clr && (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (clr || !en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/npu_spi_master.sv
// SPI master: sends a 24-bit command, waits for npu_done (with timeout), reads one response byte.
//   state         | meaning
//   ST_IDLE       | waiting for start
//   ST_SHIFT_CMD  | shifting the command frame out on mosi
//   ST_WAIT_DONE  | cs_n high, waiting for synchronised npu_done or timeout
//   ST_GAP        | cs_n high guard time before the read phase
//   ST_SHIFT_RESP | clocking the response byte in from miso
//   ST_HOLD       | cs_n high guard time after the transaction
module npu_spi_master
    import npu_spi_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CS_GAP      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] frame_in,
    output logic        busy,
    output logic [7:0]  resp_out,
    output logic        resp_valid,
    output logic        timed_out,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    input  logic        miso,
    input  logic        npu_done
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);
    localparam int BIT_W = $clog2(FRAME_BITS);

    state_t                 state;
    logic [FRAME_BITS-2:0]  tx_sh;
    logic [RESP_BITS-1:0]   rx_sh;
    logic [BIT_W-1:0]       bit_cnt;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   tmo_flag;
    logic                   done_s1;
    logic                   done_s2;
    logic                   shifting;
    logic                   sclk_clr;
    logic                   tick;

    assign shifting = (state == ST_SHIFT_CMD) || (state == ST_SHIFT_RESP);
    assign sclk_clr = !shifting;

    npu_spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (shifting),
        .clr  (sclk_clr),
        .tick (tick),
        .sclk (sclk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            tx_sh      <= '0;
            rx_sh      <= '0;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            tmo_flag   <= 1'b0;
            done_s1    <= 1'b0;
            done_s2    <= 1'b0;
            busy       <= 1'b0;
            resp_out   <= '0;
            resp_valid <= 1'b0;
            timed_out  <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= 1'b1;
        end else begin
            done_s1    <= npu_done;
            done_s2    <= done_s1;
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tx_sh   <= frame_in[FRAME_BITS-2:0];
                        mosi    <= frame_in[FRAME_BITS-1];
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= BIT_W'(FRAME_BITS - 1);
                        state   <= ST_SHIFT_CMD;
                    end
                end
                // Bits advance on the falling half-period tick so mosi is stable at every rise.
                ST_SHIFT_CMD: begin
                    if (tick && sclk) begin
                        if (bit_cnt == '0) begin
                            cs_n    <= 1'b1;
                            mosi    <= 1'b0;
                            tmo_cnt <= '0;
                            state   <= ST_WAIT_DONE;
                        end else begin
                            bit_cnt <= bit_cnt - BIT_W'(1);
                            mosi    <= tx_sh[FRAME_BITS-2];
                            tx_sh   <= {tx_sh[FRAME_BITS-3:0], 1'b0};
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_s2) begin
                        tmo_flag <= 1'b0;
                        gap_cnt  <= '0;
                        state    <= ST_GAP;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        tmo_flag <= 1'b1;
                        gap_cnt  <= '0;
                        state    <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
                        gap_cnt <= '0;
                        if (tmo_flag) begin
                            resp_out   <= '0;
                            timed_out  <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= ST_HOLD;
                        end else begin
                            cs_n    <= 1'b0;
                            mosi    <= 1'b0;
                            bit_cnt <= BIT_W'(RESP_BITS - 1);
                            state   <= ST_SHIFT_RESP;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_SHIFT_RESP: begin
                    if (tick) begin
                        if (!sclk) begin
                            rx_sh <= {rx_sh[RESP_BITS-2:0], miso};
                        end else if (bit_cnt == '0) begin
                            cs_n       <= 1'b1;
                            resp_out   <= rx_sh;
                            timed_out  <= 1'b0;
                            resp_valid <= 1'b1;
                            gap_cnt    <= '0;
                            state      <= ST_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt - BIT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
                        gap_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
